sys_ctrl_gen2: RTL

SYS_CTRL_GEN2 -- requirements
Module: sys_ctrl_gen2

---
 rtl/sys_ctrl_pkg.sv | 25 ++
 rtl/frame_timer.sv | 29 ++
 rtl/sys_ctrl_gen2.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared command codes, FSM state encoding and the default error response byte
// for the system controller.
package sys_ctrl_pkg;

    localparam logic [7:0] CMD_WRITE       = 8'hAA;
    localparam logic [7:0] CMD_READ        = 8'hBB;
    localparam logic [7:0] CMD_ALU_OPS     = 8'hCC;
    localparam logic [7:0] CMD_ALU_NOOPS   = 8'hDD;
    localparam logic [7:0] CMD_BURST_WRITE = 8'hEE;
    localparam logic [7:0] CMD_BURST_READ  = 8'hFF;

    localparam logic [7:0] ERR_BYTE_DEFAULT = 8'hE0;

    typedef enum logic [3:0] {
        IDLE, GET_ADDR, GET_CNT, GET_DATA, WRITE, READ_REQ, READ_WAIT,
        GET_OPA, GET_OPB, GET_FUN, ALU_WAIT, TX_SEND, ERROR
    } state_t;

    // States in which the controller waits on an external event and can time out.
    function automatic logic is_timed_state(state_t s);
        return s inside {GET_ADDR, GET_CNT, GET_DATA, GET_OPA, GET_OPB, GET_FUN,
                         READ_WAIT, ALU_WAIT};
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Idle-gap watchdog: counts enabled cycles since the last restart and flags the
// TIMEOUT_CYCLES-th one.
module frame_timer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic clk,
    input  logic rst,
    input  logic restart,
    input  logic enable,
    output logic expired
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] count_q;

    assign expired = enable && (count_q == CW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
        end else if (restart || !enable) begin
            count_q <= '0;
        end else if (!expired) begin
            count_q <= count_q + CW'(1);
        end
    end

endmodule

// File: rtl/sys_ctrl_gen2.sv
// Command-frame controller: decodes RX frames into register-file and ALU operations
// and streams responses to the TX FIFO.
module sys_ctrl_gen2
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned ALU_OUT_WIDTH  = 16,
    parameter int unsigned TIMEOUT_CYCLES = 1023,
    parameter logic [DATA_WIDTH-1:0] ERR_BYTE = DATA_WIDTH'(ERR_BYTE_DEFAULT)
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DATA_WIDTH-1:0]    RX_p_data,
    input  logic                     RX_d_valid,
    input  logic [DATA_WIDTH-1:0]    Rd_data,
    input  logic                     RdData_valid,
    input  logic [ALU_OUT_WIDTH-1:0] ALU_OUT,
    input  logic                     OUT_VALID,
    input  logic                     FIFO_full,
    output logic                     WrEN,
    output logic                     RdEN,
    output logic [ADDR_WIDTH-1:0]    Address,
    output logic [DATA_WIDTH-1:0]    WrData,
    output logic                     ALU_EN,
    output logic [3:0]               ALU_FUN,
    output logic                     CLK_EN,
    output logic [DATA_WIDTH-1:0]    TX_p_data,
    output logic                     TX_d_valid,
    output logic                     Frame_err,
    output logic                     Busy
);

    localparam int unsigned NBYTES = ALU_OUT_WIDTH / DATA_WIDTH;
    localparam int unsigned LW     = $clog2(NBYTES + 1);

    state_t                   state_q, state_d;
    logic [7:0]               cmd_q, cmd_d;
    logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
    logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
    logic [DATA_WIDTH-1:0]    cnt_q, cnt_d;
    logic [3:0]               fun_q, fun_d;
    logic [ALU_OUT_WIDTH-1:0] res_q, res_d;
    logic [LW-1:0]            left_q, left_d;
    logic                     wr_en_q, rd_en_q, alu_en_q, frame_err_q, busy_q;
    logic                     byte_acc, timer_expired;

    frame_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (CLK),
        .rst    (RST),
        .restart(byte_acc || (state_d != state_q)),
        .enable (is_timed_state(state_q)),
        .expired(timer_expired)
    );

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        fun_d    = fun_q;
        res_d    = res_q;
        left_d   = left_q;
        byte_acc = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (RX_d_valid) begin
                    byte_acc = 1'b1;
                    cmd_d    = RX_p_data[7:0];
                    case (RX_p_data[7:0])
                        CMD_WRITE, CMD_READ, CMD_BURST_WRITE, CMD_BURST_READ: state_d = GET_ADDR;
                        CMD_ALU_OPS:   state_d = GET_OPA;
                        CMD_ALU_NOOPS: state_d = GET_FUN;
                        default:       state_d = ERROR;
                    endcase
                end
            end
            GET_ADDR: begin
                if (RX_d_valid) begin
                    byte_acc = 1'b1;
                    addr_d   = RX_p_data[ADDR_WIDTH-1:0];
                    cnt_d    = DATA_WIDTH'(1);
                    if (cmd_q == CMD_WRITE)     state_d = GET_DATA;
                    else if (cmd_q == CMD_READ) state_d = READ_REQ;
                    else                        state_d = GET_CNT;
                end else if (timer_expired) begin
                    state_d = ERROR;
                end
            end
            GET_CNT: begin
                if (RX_d_valid) begin
                    byte_acc = 1'b1;
                    cnt_d    = RX_p_data;
                    if (RX_p_data == '0)                state_d = ERROR;
                    else if (cmd_q == CMD_BURST_WRITE)  state_d = GET_DATA;
                    else                                state_d = READ_REQ;
                end else if (timer_expired) begin
                    state_d = ERROR;
                end
            end
            GET_DATA, GET_OPA, GET_OPB: begin
                if (RX_d_valid) begin
                    byte_acc = 1'b1;
                    wdata_d  = RX_p_data;
                    state_d  = WRITE;
                    // ALU operands land at fixed register-file slots 0 and 1.
                    if (state_q == GET_OPA) addr_d = '0;
                    if (state_q == GET_OPB) addr_d = ADDR_WIDTH'(1);
                end else if (timer_expired) begin
                    state_d = ERROR;
                end
            end
            WRITE: begin
                if (cmd_q == CMD_BURST_WRITE) begin
                    addr_d  = addr_q + ADDR_WIDTH'(1);
                    cnt_d   = cnt_q - DATA_WIDTH'(1);
                    state_d = (cnt_q == DATA_WIDTH'(1)) ? IDLE : GET_DATA;
                end else if (cmd_q == CMD_ALU_OPS) begin
                    state_d = (addr_q == '0) ? GET_OPB : GET_FUN;
                end else begin
                    state_d = IDLE;
                end
            end
            READ_REQ: state_d = READ_WAIT;
            READ_WAIT: begin
                if (RdData_valid) begin
                    res_d   = ALU_OUT_WIDTH'(Rd_data);
                    left_d  = LW'(1);
                    state_d = TX_SEND;
                end else if (timer_expired) begin
                    state_d = ERROR;
                end
            end
            GET_FUN: begin
                if (RX_d_valid) begin
                    byte_acc = 1'b1;
                    fun_d    = RX_p_data[3:0];
                    state_d  = ALU_WAIT;
                end else if (timer_expired) begin
                    state_d = ERROR;
                end
            end
            ALU_WAIT: begin
                if (OUT_VALID) begin
                    res_d   = ALU_OUT;
                    left_d  = LW'(NBYTES);
                    state_d = TX_SEND;
                end else if (timer_expired) begin
                    state_d = ERROR;
                end
            end
            TX_SEND: begin
                if (!FIFO_full) begin
                    res_d  = res_q >> DATA_WIDTH;
                    left_d = left_q - LW'(1);
                    if (left_q == LW'(1)) begin
                        if (cmd_q == CMD_BURST_READ && cnt_q != DATA_WIDTH'(1)) begin
                            cnt_d   = cnt_q - DATA_WIDTH'(1);
                            addr_d  = addr_q + ADDR_WIDTH'(1);
                            state_d = READ_REQ;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                end
            end
            ERROR: begin
                // Clearing the command stops a burst read from resuming after the error byte.
                cmd_d   = '0;
                res_d   = ALU_OUT_WIDTH'(ERR_BYTE);
                left_d  = LW'(1);
                state_d = TX_SEND;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cnt_q       <= '0;
            fun_q       <= '0;
            res_q       <= '0;
            left_q      <= '0;
            wr_en_q     <= 1'b0;
            rd_en_q     <= 1'b0;
            alu_en_q    <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cnt_q       <= cnt_d;
            fun_q       <= fun_d;
            res_q       <= res_d;
            left_q      <= left_d;
            wr_en_q     <= (state_d == WRITE);
            rd_en_q     <= (state_d == READ_REQ);
            alu_en_q    <= (state_d == ALU_WAIT);
            frame_err_q <= (state_d == ERROR);
            busy_q      <= (state_d != IDLE);
        end
    end

    assign WrEN       = wr_en_q;
    assign RdEN       = rd_en_q;
    assign Address    = addr_q;
    assign WrData     = wdata_q;
    assign ALU_EN     = alu_en_q;
    assign CLK_EN     = alu_en_q;
    assign ALU_FUN    = fun_q;
    assign TX_p_data  = res_q[DATA_WIDTH-1:0];
    assign TX_d_valid = (state_q == TX_SEND) && !FIFO_full;
    assign Frame_err  = frame_err_q;
    assign Busy       = busy_q;

endmodule
